// File: rtl/lane_sum_pkg.sv
// Shared types and helpers for the lane-sum pipeline.
// FIFO state encoding, counter width and the per-lane add/saturate function.
package lane_sum_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_st_t;

  typedef struct packed {
    logic        ovf;
    logic [32:0] sum;
  } lane_res_t;

  // Add two zero-extended operands of width iw.
  // Overflow only exists when the output has no room for the carry.
  function automatic lane_res_t lane_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          iw,
    input int          ow,
    input logic        sat
  );
    logic [32:0] s;
    logic [32:0] mask;
    logic        carry;
    lane_res_t   r;
    s     = {1'b0, a} + {1'b0, b};
    mask  = (33'd1 << iw) - 33'd1;
    carry = (s >> iw) != 33'd0;
    r.ovf = 1'b0;
    r.sum = s;
    if (ow <= iw) begin
      r.ovf = carry;
      r.sum = (carry && sat) ? mask : (s & mask);
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_sum_lane.sv
// One lane of the adder: operand select, add, saturate or wrap.
// Purely combinational; all state lives in the top.
module lane_sum_lane
  import lane_sum_pkg::*;
#(
  parameter int IW = 4,
  parameter int OW = 8
) (
  input  logic [IW-1:0] a,
  input  logic [IW-1:0] b,
  input  logic [IW-1:0] def_b,
  input  logic          b_use,
  input  logic          sat_en,
  output logic [OW-1:0] sum,
  output logic          ovf
);

  lane_res_t     r;
  logic [IW-1:0] op_b;

  // Select operand B and form the lane result.
  always_comb begin
    op_b = b_use ? b : def_b;
    r    = lane_add(32'(a), 32'(op_b), IW, OW, sat_en);
    sum  = OW'(r.sum);
    ovf  = r.ovf;
  end

endmodule

// File: rtl/lane_sum_pipe.sv
// Multi-lane adder with default operand and a 2-entry skid FIFO.
// One cycle of latency, registered in_ready, saturating beat counter.
module lane_sum_pipe
  import lane_sum_pkg::*;
#(
  parameter int             LANES = 4,
  parameter int             IW    = 4,
  parameter int             OW    = 8,
  parameter logic [IW-1:0]  DEF_B = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IW-1:0]   in_a,
  input  logic [LANES*IW-1:0]   in_b,
  input  logic [LANES-1:0]      b_use,
  input  logic                  sat_en,
  input  logic                  cfg_we,
  input  logic [IW-1:0]         cfg_def,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*OW-1:0]   out_sum,
  output logic [LANES-1:0]      out_ovf,
  output logic [CNT_W-1:0]      beat_cnt
);

  if (OW < IW) begin : g_bad_ow
    $error("lane_sum_pipe: OW must be >= IW");
  end

  fifo_st_t             state;
  fifo_st_t             state_nx;
  logic [IW-1:0]        def_q;
  logic [LANES*OW-1:0]  lane_sum;
  logic [LANES*OW-1:0]  head_sum;
  logic [LANES*OW-1:0]  tail_sum;
  logic [LANES-1:0]     lane_ovf;
  logic [LANES-1:0]     head_ovf;
  logic [LANES-1:0]     tail_ovf;
  logic                 ready_q;
  logic                 accept;
  logic                 emit;
  logic [CNT_W-1:0]     cnt_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_sum_lane #(
      .IW (IW),
      .OW (OW)
    ) u_lane (
      .a      (in_a[i*IW +: IW]),
      .b      (in_b[i*IW +: IW]),
      .def_b  (def_q),
      .b_use  (b_use[i]),
      .sat_en (sat_en),
      .sum    (lane_sum[i*OW +: OW]),
      .ovf    (lane_ovf[i])
    );
  end

  assign accept    = in_valid && ready_q;
  assign emit      = out_valid && out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_sum   = head_sum;
  assign out_ovf   = head_ovf;
  assign beat_cnt  = cnt_q;

  // FIFO occupancy transitions.
  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (accept) state_nx = ONE;
      ONE: begin
        if (accept && !emit) state_nx = FULL;
        else if (emit && !accept) state_nx = EMPTY;
      end
      FULL: if (emit) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // State, ready flag, default operand and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
      def_q   <= DEF_B;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx != FULL);
      if (cfg_we) def_q <= cfg_def;
      if (accept && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Head feeds the output; tail catches a beat while the head stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_sum <= '0;
      head_ovf <= '0;
      tail_sum <= '0;
      tail_ovf <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_sum <= lane_sum;
            head_ovf <= lane_ovf;
          end
        end
        ONE: begin
          if (accept && emit) begin
            head_sum <= lane_sum;
            head_ovf <= lane_ovf;
          end else if (accept) begin
            tail_sum <= lane_sum;
            tail_ovf <= lane_ovf;
          end
        end
        FULL: begin
          if (emit) begin
            head_sum <= tail_sum;
            head_ovf <= tail_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
